pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and occupancy width for the pipeline stage register
package pipe_pkg;

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one payload register with load enable, source select and sync clear
module pipe_slot #(
    parameter int             W       = 64,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         cpu_clk,
    input  logic         clr,
    input  logic         load,
    input  logic         sel_skid,
    input  logic [W-1:0] load_data,
    input  logic [W-1:0] skid_data,
    output logic [W-1:0] slot_data
);

    logic [W-1:0] slot_q;
    logic [W-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load) begin
            slot_d = sel_skid ? skid_data : load_data;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (clr) begin
            slot_q <= RST_VAL;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_data = slot_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with skid slot, hold and flush
// Optional trace sideband (trace_in/out, trace_commit, trace_cnt) under PIPE_TRACE_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = 64,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               TRACE_W = 32
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    input  logic               hold,
    input  logic               flush,
    output logic [CNT_W-1:0]   count
`ifdef PIPE_TRACE_EN
    ,
    input  logic [TRACE_W-1:0] trace_in,
    output logic [TRACE_W-1:0] trace_out,
    output logic               trace_commit,
    output logic [31:0]        trace_cnt
`endif
);

`ifdef PIPE_TRACE_EN
    localparam int TRACE_BITS = TRACE_W;
`else
    localparam int TRACE_BITS = 0 * TRACE_W;
`endif
    localparam int                SLOT_W   = WIDTH + TRACE_BITS;
    // Trace bits sit above the payload and always clear to zero.
    localparam logic [SLOT_W-1:0] SLOT_RST = SLOT_W'(RST_VAL);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic              in_fire;
    logic              out_fire;
    logic              clr;
    logic              main_load;
    logic              main_sel_skid;
    logic              skid_load;
    logic [SLOT_W-1:0] slot_in;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;

`ifdef PIPE_TRACE_EN
    assign slot_in = {trace_in, in_data};
`else
    assign slot_in = in_data;
`endif

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_d = BUSY;
                BUSY: begin
                    if (in_fire && !out_fire) begin
                        state_d = FULL;
                    end else if (!in_fire && out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (out_fire) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is a function of state and stall controls only; out_ready never reaches it.
    always_comb begin
        in_ready      = (state_q != FULL) && !hold && !flush && !cpu_rst;
        out_valid     = (state_q != EMPTY) && !hold;
        in_fire       = in_valid && in_ready;
        out_fire      = out_valid && out_ready;
        clr           = cpu_rst || flush;
        main_sel_skid = (state_q == FULL);
        main_load     = ((state_q == EMPTY) && in_fire)
                     || ((state_q == BUSY) && in_fire && out_fire)
                     || ((state_q == FULL) && out_fire);
        skid_load     = (state_q == BUSY) && in_fire && !out_fire;
        case (state_q)
            BUSY:    count = CNT_W'(1);
            FULL:    count = CNT_W'(2);
            default: count = CNT_W'(0);
        endcase
    end

    pipe_slot #(.W(SLOT_W), .RST_VAL(SLOT_RST)) u_main (
        .cpu_clk   (cpu_clk),
        .clr       (clr),
        .load      (main_load),
        .sel_skid  (main_sel_skid),
        .load_data (slot_in),
        .skid_data (skid_q),
        .slot_data (main_q)
    );

    pipe_slot #(.W(SLOT_W), .RST_VAL(SLOT_RST)) u_skid (
        .cpu_clk   (cpu_clk),
        .clr       (clr),
        .load      (skid_load),
        .sel_skid  (1'b0),
        .load_data (slot_in),
        .skid_data (skid_q),
        .slot_data (skid_q)
    );

    assign out_data = main_q[WIDTH-1:0];

`ifdef PIPE_TRACE_EN
    logic        trace_commit_q;
    logic        trace_commit_d;
    logic [31:0] trace_cnt_q;
    logic [31:0] trace_cnt_d;

    always_comb begin
        trace_commit_d = out_fire;
        trace_cnt_d    = trace_cnt_q + 32'(out_fire);
    end

    // flush leaves the commit counter running; only reset clears it.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            trace_commit_q <= 1'b0;
            trace_cnt_q    <= '0;
        end else begin
            trace_commit_q <= trace_commit_d;
            trace_cnt_q    <= trace_cnt_d;
        end
    end

    assign trace_out    = main_q[SLOT_W-1:WIDTH];
    assign trace_commit = trace_commit_q;
    assign trace_cnt    = trace_cnt_q;
`endif

endmodule
